// File: rtl/multi_monostable_pkg.sv
// Shared types and constants for the multi-channel one-shot pulse generator.
package multi_monostable_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_HOLDOFF
    } state_e;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_BOTH = 2;

    localparam int unsigned SYNC_DEPTH = 2;

    // Qualifies an edge between the previous and current trigger samples.
    function automatic logic edge_hit(input int unsigned mode, input logic cur, input logic prev);
        case (mode)
            EDGE_RISE: return cur & ~prev;
            EDGE_FALL: return ~cur & prev;
            default:   return cur ^ prev;
        endcase
    endfunction

endpackage

// File: rtl/multi_monostable_if.sv
// Trigger/config/result bundle of the multi-channel one-shot block.
interface multi_monostable_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 16
);
    logic [CHANNELS-1:0] trigger;
    logic [CNT_W-1:0]    pulse_len;
    logic [CNT_W-1:0]    holdoff_len;
    logic [CHANNELS-1:0] retrig_en;
    logic [CHANNELS-1:0] pulse;
    logic [CHANNELS-1:0] done;
    logic [CHANNELS-1:0] busy;

    modport master (
        output trigger, pulse_len, holdoff_len, retrig_en,
        input  pulse, done, busy
    );

    modport slave (
        input  trigger, pulse_len, holdoff_len, retrig_en,
        output pulse, done, busy
    );
endinterface

// File: rtl/multi_monostable_ch.sv
// One one-shot channel: optional synchronizer, edge detect, FSM and counter.
// Synchronizer is built only when MULTI_MONOSTABLE_SYNC_EN is defined.
module multi_monostable_ch
    import multi_monostable_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned EDGE_MODE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic [CNT_W-1:0] pulse_len,
    input  logic [CNT_W-1:0] holdoff_len,
    input  logic             retrig_en,
    output logic             pulse,
    output logic             done,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             trig_in;
    logic             trig_q;
    logic             prev_q;
    logic             edge_seen;
    logic             len_ok;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

`ifdef MULTI_MONOSTABLE_SYNC_EN
    logic [SYNC_DEPTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], trigger};
        end
    end

    assign trig_in = sync_q[SYNC_DEPTH-1];
`else
    assign trig_in = trigger;
`endif

    // History loads 0 so a trigger high across reset release reads as a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            trig_q <= trig_in;
            prev_q <= trig_q;
        end
    end

    assign edge_seen = edge_hit(EDGE_MODE, trig_q, prev_q);
    assign len_ok    = (pulse_len != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse   <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (edge_seen && len_ok) begin
                        state_q <= ST_ACTIVE;
                        cnt_q   <= pulse_len;
                        pulse   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    // Reload wins over both decrement and expiry.
                    if (edge_seen && retrig_en && len_ok) begin
                        cnt_q <= pulse_len;
                    end else if (cnt_q <= CNT_ONE) begin
                        pulse <= 1'b0;
                        done  <= 1'b1;
                        cnt_q <= holdoff_len;
                        if (holdoff_len != '0) begin
                            state_q <= ST_HOLDOFF;
                        end else begin
                            state_q <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    pulse   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_monostable.sv
// Multi-channel one-shot pulse generator; CHANNELS independent channels sharing
// pulse_len/holdoff_len. Define MULTI_MONOSTABLE_SYNC_EN for asynchronous triggers.
module multi_monostable
    import multi_monostable_pkg::*;
#(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned EDGE_MODE = EDGE_RISE
) (
    input logic               clk,
    input logic               rst,
    multi_monostable_if.slave bus
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        multi_monostable_ch #(
            .CNT_W    (CNT_W),
            .EDGE_MODE(EDGE_MODE)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .trigger    (bus.trigger[i]),
            .pulse_len  (bus.pulse_len),
            .holdoff_len(bus.holdoff_len),
            .retrig_en  (bus.retrig_en[i]),
            .pulse      (bus.pulse[i]),
            .done       (bus.done[i]),
            .busy       (bus.busy[i])
        );
    end

endmodule

// File: tb/tb_multi_monostable.sv
// Bench for multi_monostable: rise/fall/both instances share stimulus; a timestamp
// model pushes per-cycle expectations that a monitor pops and compares.
module tb_multi_monostable;

    localparam int CH   = 4;
    localparam int CW   = 16;
    localparam int NDUT = 3;
    localparam int MAXC = 4000;
`ifdef MULTI_MONOSTABLE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [NDUT*CH-1:0] p;
        logic [NDUT*CH-1:0] d;
        logic [NDUT*CH-1:0] b;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] trig = '0;
    logic [CH-1:0] retrig = '0;
    logic [CW-1:0] plen = '0;
    logic [CW-1:0] hlen = '0;

    logic [CH-1:0] n_retrig;
    logic [CW-1:0] n_plen;
    logic [CW-1:0] n_hlen;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [CH-1:0] hist [MAXC];
    bit            open_m   [NDUT][CH];
    int            hi_end   [NDUT][CH];
    int            lock_end [NDUT][CH];
    exp_t          sb_q [$];

    always #5 clk = ~clk;

    multi_monostable_if #(.CHANNELS(CH), .CNT_W(CW)) bus_r ();
    multi_monostable_if #(.CHANNELS(CH), .CNT_W(CW)) bus_f ();
    multi_monostable_if #(.CHANNELS(CH), .CNT_W(CW)) bus_b ();

    assign bus_r.trigger = trig;  assign bus_r.retrig_en = retrig;
    assign bus_r.pulse_len = plen; assign bus_r.holdoff_len = hlen;
    assign bus_f.trigger = trig;  assign bus_f.retrig_en = retrig;
    assign bus_f.pulse_len = plen; assign bus_f.holdoff_len = hlen;
    assign bus_b.trigger = trig;  assign bus_b.retrig_en = retrig;
    assign bus_b.pulse_len = plen; assign bus_b.holdoff_len = hlen;

    multi_monostable #(.CHANNELS(CH), .CNT_W(CW), .EDGE_MODE(0)) u_rise (
        .clk(clk), .rst(rst), .bus(bus_r)
    );
    multi_monostable #(.CHANNELS(CH), .CNT_W(CW), .EDGE_MODE(1)) u_fall (
        .clk(clk), .rst(rst), .bus(bus_f)
    );
    multi_monostable #(.CHANNELS(CH), .CNT_W(CW), .EDGE_MODE(2)) u_both (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    function automatic logic [CH-1:0] hist_at(input int t);
        if (t < 1 || t >= MAXC) return '0;
        return hist[t];
    endfunction

    task automatic model_reset();
        for (int m = 0; m < NDUT; m++) begin
            for (int c = 0; c < CH; c++) begin
                open_m[m][c]   = 1'b0;
                hi_end[m][c]   = -1;
                lock_end[m][c] = -2;
            end
        end
    endtask

    // Pulse is high after edges [start, hi_end]; busy after edges up to lock_end.
    task automatic model_step(input int t);
        logic [CH-1:0] cur;
        logic [CH-1:0] prv;
        exp_t          e;
        bit            ev;
        bit            dn;
        cur = hist_at(t - LAT);
        prv = hist_at(t - LAT - 1);
        e   = '0;
        for (int m = 0; m < NDUT; m++) begin
            for (int c = 0; c < CH; c++) begin
                case (m)
                    0:       ev = cur[c] && !prv[c];
                    1:       ev = !cur[c] && prv[c];
                    default: ev = cur[c] != prv[c];
                endcase
                dn = 1'b0;
                if (open_m[m][c]) begin
                    if (ev && retrig[c] && plen != 0) begin
                        hi_end[m][c] = t + int'(plen) - 1;
                    end else if (t == hi_end[m][c] + 1) begin
                        open_m[m][c]   = 1'b0;
                        dn             = 1'b1;
                        lock_end[m][c] = hi_end[m][c] + int'(hlen);
                    end
                end else if (t >= lock_end[m][c] + 2 && ev && plen != 0) begin
                    open_m[m][c] = 1'b1;
                    hi_end[m][c] = t + int'(plen) - 1;
                end
                e.p[m*CH+c] = open_m[m][c];
                e.d[m*CH+c] = dn;
                e.b[m*CH+c] = open_m[m][c] || (t <= lock_end[m][c]);
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic step(input logic [CH-1:0] v);
        @(negedge clk);
        trig   = v;
        plen   = n_plen;
        hlen   = n_hlen;
        retrig = n_retrig;
        @(posedge clk);
        cyc++;
        if (cyc < MAXC) hist[cyc] = trig;
        model_step(cyc);
    endtask

    task automatic hold(input logic [CH-1:0] v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic chk(input string nm, input logic [NDUT*CH-1:0] act,
                       input logic [NDUT*CH-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
        end
    endtask

    // Monitor: outputs must read zero shortly after any reset assertion, otherwise
    // each cycle must match the next queued expectation.
    always @(negedge clk or posedge rst) begin
        exp_t e;
        if (rst) begin
            #1;
            chk("rst_pulse", {bus_b.pulse, bus_f.pulse, bus_r.pulse}, '0);
            chk("rst_done",  {bus_b.done,  bus_f.done,  bus_r.done},  '0);
            chk("rst_busy",  {bus_b.busy,  bus_f.busy,  bus_r.busy},  '0);
        end else if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("pulse", {bus_b.pulse, bus_f.pulse, bus_r.pulse}, e.p);
            chk("done",  {bus_b.done,  bus_f.done,  bus_r.done},  e.d);
            chk("busy",  {bus_b.busy,  bus_f.busy,  bus_r.busy},  e.b);
        end
    end

    initial begin
        logic [CH-1:0] v;
        n_plen   = 16'd5;
        n_hlen   = '0;
        n_retrig = '0;
        model_reset();
        #3 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic 5-cycle pulse on ch0.
        hold(4'b0001, 3);
        hold(4'b0000, 10);

        // Retrigger on ch1, second edge 4 cycles in.
        n_plen = 16'd8; n_retrig = 4'b0010;
        hold(4'b0010, 1); hold(4'b0000, 3); hold(4'b0010, 1); hold(4'b0000, 20);
        n_retrig = 4'b0000;
        hold(4'b0010, 1); hold(4'b0000, 3); hold(4'b0010, 1); hold(4'b0000, 20);

        // Holdoff: edges 2 and 5 cycles after pulse end on ch2.
        n_plen = 16'd3; n_hlen = 16'd4;
        hold(4'b0100, 1); hold(4'b0000, 4); hold(4'b0100, 1);
        hold(4'b0000, 2); hold(4'b0100, 1); hold(4'b0000, 15);

        // Long high level on ch3: two pulses in both-edge mode.
        n_hlen = '0;
        hold(4'b1000, 10); hold(4'b0000, 12);

        // Zero length edge is ignored.
        n_plen = '0;
        hold(4'b0001, 1); hold(4'b0000, 6);

        // Simultaneous edges on every channel.
        n_plen = 16'd6; n_hlen = 16'd2;
        hold(4'b1111, 2); hold(4'b0000, 14);

        // Randomized traffic.
        v = '0;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                n_plen   = CW'($urandom_range(0, 12));
                n_hlen   = CW'($urandom_range(0, 5));
                n_retrig = CH'($urandom);
            end
            v = v ^ (CH'($urandom) & CH'($urandom));
            step(v);
        end
        hold(4'b0000, 30);

        // Asynchronous reset in the middle of a pulse.
        n_plen = 16'd20; n_hlen = '0; n_retrig = '0;
        hold(4'b0001, 3); hold(4'b0000, 2);
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        cyc = 0;
        rst = 1'b0;
        hold(4'b0000, 10);
        hold(4'b0001, 1); hold(4'b0000, 25);

        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
